clear_lines: RTL and testbench

Board-compaction stage run after a placed piece has been written into board RAM. On `start`, it scans the 10-wide board bottom-up and removes every completely filled row. Surviving rows are copied down into a contiguous stack, and the freed rows at the top are zero-filled. It reports how many rows were removed to the score/level logic.

---
 rtl/clear_lines.sv | 167 ++++++++++++++++
 tb/tb_clear_lines.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/clear_lines.sv
// Board compaction: scans rows bottom-up, drops full rows, copies survivors down
// into a contiguous stack and zero-fills the freed rows at the top.
module clear_lines #(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 20,
    parameter int DATA_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [7:0]        ram_addr,
    input  logic [DATA_W-1:0] ram_q,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_data,
    output logic              busy,
    output logic              done,
    output logic [4:0]        lines_cleared
);

    typedef enum logic [2:0] {
        IDLE, SCAN_RD, SCAN_CHK, NEXT_ROW, COPY_RD, COPY_WR, FILL_WR, DONE_ST
    } state_t;

    localparam logic [3:0] LAST_COL = 4'(WIDTH - 1);
    localparam logic [4:0] LAST_ROW = 5'(HEIGHT - 1);

    state_t     r_state, w_state_nxt;
    logic [4:0] r_src, w_src_nxt;
    logic [4:0] r_dst, w_dst_nxt;
    logic [4:0] r_cnt, w_cnt_nxt;
    logic [3:0] r_col, w_col_nxt;
    logic       r_full, w_full_nxt;
    logic       w_tail;
    logic [7:0] w_src_addr, w_dst_addr;

    assign w_src_addr    = 8'(r_src) * 8'(WIDTH) + 8'(r_col);
    assign w_dst_addr    = 8'(r_dst) * 8'(WIDTH) + 8'(r_col);
    assign busy          = (r_state != IDLE);
    assign lines_cleared = r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_src   <= '0;
            r_dst   <= '0;
            r_cnt   <= '0;
            r_col   <= '0;
            r_full  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_dst   <= w_dst_nxt;
            r_cnt   <= w_cnt_nxt;
            r_col   <= w_col_nxt;
            r_full  <= w_full_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_dst_nxt   = r_dst;
        w_cnt_nxt   = r_cnt;
        w_col_nxt   = r_col;
        w_full_nxt  = r_full;
        w_tail      = 1'b0;
        ram_addr    = '0;
        ram_wren    = 1'b0;
        ram_data    = '0;
        done        = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_src_nxt   = LAST_ROW;
                    w_dst_nxt   = LAST_ROW;
                    w_col_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_full_nxt  = 1'b1;
                    w_state_nxt = SCAN_RD;
                end
            end
            SCAN_RD: begin
                ram_addr    = w_src_addr;
                w_state_nxt = SCAN_CHK;
            end
            SCAN_CHK: begin
                if (ram_q == '0) begin
                    w_full_nxt  = 1'b0;
                    w_state_nxt = NEXT_ROW;
                end else if (r_col == LAST_COL) begin
                    w_state_nxt = NEXT_ROW;
                end else begin
                    w_col_nxt   = r_col + 4'd1;
                    w_state_nxt = SCAN_RD;
                end
            end
            NEXT_ROW: begin
                w_tail = 1'b1;
                if (r_full) begin
                    w_cnt_nxt = r_cnt + 5'd1;
                end else if (r_dst != r_src) begin
                    w_tail      = 1'b0;
                    w_col_nxt   = '0;
                    w_state_nxt = COPY_RD;
                end else begin
                    w_dst_nxt = r_dst - 5'd1;
                end
            end
            COPY_RD: begin
                ram_addr    = w_src_addr;
                w_state_nxt = COPY_WR;
            end
            COPY_WR: begin
                ram_addr = w_dst_addr;
                ram_data = ram_q;
                ram_wren = 1'b1;
                if (r_col == LAST_COL) begin
                    w_dst_nxt = r_dst - 5'd1;
                    w_tail    = 1'b1;
                end else begin
                    w_col_nxt   = r_col + 4'd1;
                    w_state_nxt = COPY_RD;
                end
            end
            FILL_WR: begin
                // dst walks the freed rows from cnt-1 up to row 0
                ram_addr = w_dst_addr;
                ram_wren = 1'b1;
                if (r_col == LAST_COL) begin
                    if (r_dst == '0) begin
                        w_state_nxt = DONE_ST;
                    end else begin
                        w_dst_nxt = r_dst - 5'd1;
                        w_col_nxt = '0;
                    end
                end else begin
                    w_col_nxt = r_col + 4'd1;
                end
            end
            DONE_ST: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase

        // Shared end-of-row step: advance upward or finish with the fill phase.
        if (w_tail) begin
            if (r_src == '0) begin
                if (w_cnt_nxt != '0) begin
                    w_col_nxt   = '0;
                    w_dst_nxt   = w_cnt_nxt - 5'd1;
                    w_state_nxt = FILL_WR;
                end else begin
                    w_state_nxt = DONE_ST;
                end
            end else begin
                w_src_nxt   = r_src - 5'd1;
                w_col_nxt   = '0;
                w_full_nxt  = 1'b1;
                w_state_nxt = SCAN_RD;
            end
        end
    end

endmodule

// File: tb/tb_clear_lines.sv
// Directed bench for clear_lines: board RAM model, hand-computed boards, cycle counts.
module tb_clear_lines;
    localparam int W = 10;
    localparam int H = 20;
    localparam int N = W * H;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] ram_addr;
    logic [5:0] ram_q;
    logic       ram_wren;
    logic [5:0] ram_data;
    logic       busy;
    logic       done;
    logic [4:0] lines_cleared;

    logic [5:0] mem  [N];
    logic [5:0] img  [N];
    logic [5:0] expb [N];
    logic       ld_req = 1'b0;

    int nchk  = 0;
    int nfail = 0;
    int cyc, wr, b1;
    bit found;

    always #5 clk = ~clk;

    clear_lines #(.WIDTH(W), .HEIGHT(H), .DATA_W(6)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .ram_addr      (ram_addr),
        .ram_q         (ram_q),
        .ram_wren      (ram_wren),
        .ram_data      (ram_data),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared)
    );

    // 1-cycle synchronous RAM; ld_req copies the prepared image in one edge
    always @(posedge clk) begin
        if (ld_req) begin
            for (int i = 0; i < N; i++) mem[i] <= img[i];
        end else if (ram_wren) begin
            mem[int'(ram_addr)] <= ram_data;
        end
        ram_q <= mem[int'(ram_addr)];
    end

    task automatic chk(input string tag, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic clr_boards();
        for (int i = 0; i < N; i++) begin
            img[i]  = '0;
            expb[i] = '0;
        end
    endtask

    task automatic load();
        @(negedge clk) ld_req = 1'b1;
        @(negedge clk) ld_req = 1'b0;
    endtask

    function automatic int board_diff();
        int d = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== expb[i]) d++;
        return d;
    endfunction

    // Cycle 1 is the first cycle after start is sampled; returns the cycle done is seen.
    task automatic run_pass(input int pulse_at, output int c, output int w, output int bsy1);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        c = 1; w = 0; bsy1 = int'(busy);
        while (1) begin
            start = (c == pulse_at);
            if (ram_wren) w++;
            if (done || c >= 3000) break;
            @(negedge clk);
            c++;
        end
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        clr_boards();
        load();
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_wren", int'(ram_wren), 0);
        chk("rst_addr", int'(ram_addr), 0);
        chk("rst_data", int'(ram_data), 0);
        chk("rst_lines", int'(lines_cleared), 0);
        reset = 1'b0;

        // empty board
        clr_boards();
        load();
        run_pass(0, cyc, wr, b1);
        chk("t1_done", int'(done), 1);
        chk("t1_cycles", cyc, 61);
        chk("t1_writes", wr, 0);
        chk("t1_busy_rise", b1, 1);
        chk("t1_lines", int'(lines_cleared), 0);
        @(negedge clk);
        chk("t1_busy_fall", int'(busy), 0);
        chk("t1_done_pulse", int'(done), 0);

        // single full bottom row
        clr_boards();
        for (int x = 0; x < W; x++) img[19*W+x] = 6'd3;
        img[18*W+4] = 6'd5;
        expb[19*W+4] = 6'd5;
        load();
        run_pass(0, cyc, wr, b1);
        chk("t2_done", int'(done), 1);
        chk("t2_lines", int'(lines_cleared), 1);
        chk("t2_cycles", cyc, 469);
        chk("t2_writes", wr, 200);
        chk("t2_cell", int'(mem[19*W+4]), 5);
        chk("t2_board", board_diff(), 0);

        // four full rows, survivor row 15
        clr_boards();
        for (int y = 16; y < 20; y++)
            for (int x = 0; x < W; x++) img[y*W+x] = 6'(y - 15);
        img[15*W+0] = 6'd1;
        img[15*W+9] = 6'd2;
        expb[19*W+0] = 6'd1;
        expb[19*W+9] = 6'd2;
        load();
        run_pass(0, cyc, wr, b1);
        chk("t3_done", int'(done), 1);
        chk("t3_lines", int'(lines_cleared), 4);
        chk("t3_cycles", cyc, 495);
        chk("t3_board", board_diff(), 0);

        // interleaved full rows 17 and 19
        clr_boards();
        for (int x = 0; x < W; x++) begin
            img[19*W+x] = 6'd2;
            img[17*W+x] = 6'd6;
        end
        img[18*W+2] = 6'd7;
        img[16*W+5] = 6'd1;
        img[15*W+3] = 6'd4;
        img[14*W+7] = 6'd6;
        expb[19*W+2] = 6'd7;
        expb[18*W+5] = 6'd1;
        expb[17*W+3] = 6'd4;
        expb[16*W+7] = 6'd6;
        load();
        run_pass(0, cyc, wr, b1);
        chk("t4_done", int'(done), 1);
        chk("t4_lines", int'(lines_cleared), 2);
        chk("t4_cycles", cyc, 477);
        chk("t4_writes", wr, 200);
        chk("t4_board", board_diff(), 0);

        // entirely full board: only fill writes, no copies
        clr_boards();
        for (int i = 0; i < N; i++) img[i] = 6'((i % 5) + 1);
        load();
        run_pass(0, cyc, wr, b1);
        chk("t5_done", int'(done), 1);
        chk("t5_lines", int'(lines_cleared), 20);
        chk("t5_cycles", cyc, 621);
        chk("t5_writes", wr, 200);
        chk("t5_board", board_diff(), 0);

        // reset asserted during the first copy write
        clr_boards();
        for (int x = 0; x < W; x++) img[19*W+x] = 6'd3;
        img[18*W+4] = 6'd5;
        load();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ram_wren) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("t6_copy_seen", int'(found), 1);
        reset = 1'b1;
        #1;
        chk("t6_wren", int'(ram_wren), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_lines", int'(lines_cleared), 0);
        @(negedge clk) reset = 1'b0;

        // start pulsed mid-pass is ignored
        clr_boards();
        for (int y = 16; y < 20; y++)
            for (int x = 0; x < W; x++) img[y*W+x] = 6'd1;
        img[15*W+0] = 6'd1;
        img[15*W+9] = 6'd2;
        expb[19*W+0] = 6'd1;
        expb[19*W+9] = 6'd2;
        load();
        run_pass(10, cyc, wr, b1);
        chk("t7_done", int'(done), 1);
        chk("t7_cycles", cyc, 495);
        chk("t7_lines", int'(lines_cleared), 4);
        chk("t7_board", board_diff(), 0);
        repeat (3) @(negedge clk);
        chk("t7_idle", int'(busy), 0);
        chk("t7_lines_hold", int'(lines_cleared), 4);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
